// File: rtl/glb_proc_ring_arbiter.sv
// Ring-stop arbiter: merges upstream ring traffic with local tile injections into a
// registered downstream stage, using a one-entry hold buffer and a local starvation counter.
module glb_proc_ring_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ring_in_valid,
  input  logic [DATA_WIDTH-1:0] ring_in_data,
  output logic                  ring_in_ready,
  input  logic                  local_req_valid,
  input  logic [DATA_WIDTH-1:0] local_req_data,
  output logic                  local_req_ready,
  output logic                  ring_out_valid,
  output logic [DATA_WIDTH-1:0] ring_out_data,
  input  logic                  ring_out_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic { PASS = 1'b0, HOLD = 1'b1 } state_t;
  typedef enum logic [1:0] { SRC_NONE, SRC_LOCAL, SRC_HOLD, SRC_RING } src_t;

  state_t                state_q, state_d;
  logic                  out_v_q, out_v_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [3:0]            cnt_q, cnt_d;

  logic adv;
  logic ring_acc;
  logic starved;
  src_t src;

  // The ring can only be accepted while the hold slot is free, so a held packet is never overwritten.
  assign ring_in_ready   = !reset && (state_q == PASS);
  assign local_req_ready = (src == SRC_LOCAL);
  assign ring_out_valid  = out_v_q;
  assign ring_out_data   = out_data_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    adv         = !out_v_q || ring_out_ready;
    ring_acc    = ring_in_valid && ring_in_ready;
    starved     = local_req_valid && (cnt_q == LIMIT);
    src         = SRC_NONE;
    state_d     = state_q;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    hold_data_d = hold_data_q;
    cnt_d       = cnt_q;

    if (!reset && adv) begin
      if (starved)                src = SRC_LOCAL;
      else if (state_q == HOLD)   src = SRC_HOLD;
      else if (ring_acc)          src = SRC_RING;
      else if (local_req_valid)   src = SRC_LOCAL;
    end

    if (adv) begin
      out_v_d = (src != SRC_NONE);
      case (src)
        SRC_LOCAL: out_data_d = local_req_data;
        SRC_HOLD:  out_data_d = hold_data_q;
        SRC_RING:  out_data_d = ring_in_data;
        default:   out_data_d = out_data_q;
      endcase
    end

    // An accepted ring packet that did not win the output slot is parked in hold.
    if (src == SRC_HOLD) begin
      state_d = PASS;
    end else if (ring_acc && (src != SRC_RING)) begin
      state_d     = HOLD;
      hold_data_d = ring_in_data;
    end

    if (!local_req_valid || (src == SRC_LOCAL)) cnt_d = '0;
    else if (cnt_q != LIMIT)                    cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= PASS;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      hold_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      hold_data_q <= hold_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_glb_proc_ring_arbiter.sv
// Scoreboard bench for glb_proc_ring_arbiter: directed vectors with hand-computed
// expected output order, then a random phase checking per-source ordering and starvation.
module tb_glb_proc_ring_arbiter;

  localparam int DW = 64;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ring_in_valid;
  logic [DW-1:0] ring_in_data;
  logic          ring_in_ready;
  logic          local_req_valid;
  logic [DW-1:0] local_req_data;
  logic          local_req_ready;
  logic          ring_out_valid;
  logic [DW-1:0] ring_out_data;
  logic          ring_out_ready;

  int            n_tests = 0;
  int            n_fail  = 0;
  bit            rand_mode = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ring_q[$];
  logic [DW-1:0] loc_q[$];

  always #5 clk = ~clk;

  glb_proc_ring_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk             (clk),
    .reset           (reset),
    .ring_in_valid   (ring_in_valid),
    .ring_in_data    (ring_in_data),
    .ring_in_ready   (ring_in_ready),
    .local_req_valid (local_req_valid),
    .local_req_data  (local_req_data),
    .local_req_ready (local_req_ready),
    .ring_out_valid  (ring_out_valid),
    .ring_out_data   (ring_out_data),
    .ring_out_ready  (ring_out_ready)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [DW-1:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h expected no output", nm, act);
  endtask

  // Monitor: pops the scoreboard on every downstream handshake.
  always @(negedge clk) begin
    if (!reset && ring_out_valid && ring_out_ready) begin
      if (!rand_mode) begin
        if (exp_q.size() == 0) unexpected("out_unexpected", ring_out_data);
        else check("out_data", ring_out_data, exp_q.pop_front());
      end else if (ring_out_data[DW-1]) begin
        if (loc_q.size() == 0) unexpected("local_out_unexpected", ring_out_data);
        else check("local_out_order", ring_out_data, loc_q.pop_front());
      end else begin
        if (ring_q.size() == 0) unexpected("ring_out_unexpected", ring_out_data);
        else check("ring_out_order", ring_out_data, ring_q.pop_front());
      end
    end
  end

  // One cycle of directed stimulus; eov < 0 skips the output check.
  task automatic step(input bit rst, input bit rv, input logic [DW-1:0] rd,
                      input bit lv, input logic [DW-1:0] ld, input bit ordy,
                      input bit erir, input bit elrdy,
                      input int eov, input logic [DW-1:0] eod, input string nm);
    reset           = rst;
    ring_in_valid   = rv;
    ring_in_data    = rd;
    local_req_valid = lv;
    local_req_data  = ld;
    ring_out_ready  = ordy;
    @(negedge clk);
    check({nm, "_ring_in_ready"}, DW'(ring_in_ready), DW'(erir));
    check({nm, "_local_req_ready"}, DW'(local_req_ready), DW'(elrdy));
    if (eov >= 0) begin
      check({nm, "_out_valid"}, DW'(ring_out_valid), DW'(eov[0]));
      if (eov == 1) check({nm, "_out_data"}, ring_out_data, eod);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] rid;
    logic [DW-1:0] lid;
    int            wait_cnt;
    bit            gen;
    bit            acc_r;
    bit            acc_l;

    reset = 1'b1; ring_in_valid = 1'b0; ring_in_data = '0;
    local_req_valid = 1'b0; local_req_data = '0; ring_out_ready = 1'b1;

    // Reset: traffic presented during reset is refused and nothing emerges.
    step(1, 1, 'h99, 1, 'h98, 1, 0, 0, 0, 0, "rst0");
    step(1, 1, 'h99, 1, 'h98, 1, 0, 0, 0, 0, "rst1");

    // Ring-only stream: one-cycle pass-through, ready stays high.
    exp_q.push_back('h11); exp_q.push_back('h22); exp_q.push_back('h33);
    step(0, 1, 'h11, 0, 0, 1, 1, 0, 0, 0,     "a0");
    step(0, 1, 'h22, 0, 0, 1, 1, 0, 1, 'h11,  "a1");
    step(0, 1, 'h33, 0, 0, 1, 1, 0, 1, 'h22,  "a2");
    step(0, 0, 0,    0, 0, 1, 1, 0, 1, 'h33,  "a3");
    step(0, 0, 0,    0, 0, 1, 1, 0, 0, 0,     "a4");

    // Local-only injection with idle ring.
    exp_q.push_back('h5A);
    step(0, 0, 0, 1, 'h5A, 1, 1, 1, 0, 0,     "b0");
    step(0, 0, 0, 0, 0,    1, 1, 0, 1, 'h5A,  "b1");
    check("b_cnt_zero", DW'(dut.cnt_q), 0);
    step(0, 0, 0, 0, 0,    1, 1, 0, 0, 0,     "b2");

    // Ring every cycle + local 0xAA: four ring packets, then forced local, then hold.
    exp_q.push_back('h01); exp_q.push_back('h02); exp_q.push_back('h03);
    exp_q.push_back('h04); exp_q.push_back('hAA); exp_q.push_back('h05);
    exp_q.push_back('h06); exp_q.push_back('h07);
    step(0, 1, 'h01, 1, 'hAA, 1, 1, 0, 0, 0,     "c0");
    step(0, 1, 'h02, 1, 'hAA, 1, 1, 0, 1, 'h01,  "c1");
    step(0, 1, 'h03, 1, 'hAA, 1, 1, 0, 1, 'h02,  "c2");
    step(0, 1, 'h04, 1, 'hAA, 1, 1, 0, 1, 'h03,  "c3");
    step(0, 1, 'h05, 1, 'hAA, 1, 1, 1, 1, 'h04,  "c4");
    step(0, 1, 'h06, 0, 0,    1, 0, 0, 1, 'hAA,  "c5");
    step(0, 1, 'h06, 0, 0,    1, 1, 0, 1, 'h05,  "c6");
    step(0, 1, 'h07, 0, 0,    1, 1, 0, 1, 'h06,  "c7");
    step(0, 0, 0,    0, 0,    1, 1, 0, 1, 'h07,  "c8");
    step(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     "c9");

    // Downstream stall for three cycles: output holds, one packet parks in hold.
    exp_q.push_back('h10); exp_q.push_back('h20); exp_q.push_back('h30);
    step(0, 1, 'h10, 0, 0, 1, 1, 0, 0, 0,     "d0");
    step(0, 1, 'h20, 0, 0, 0, 1, 0, 1, 'h10,  "d1");
    step(0, 1, 'h30, 0, 0, 0, 0, 0, 1, 'h10,  "d2");
    step(0, 1, 'h30, 0, 0, 0, 0, 0, 1, 'h10,  "d3");
    step(0, 1, 'h30, 0, 0, 1, 0, 0, 1, 'h10,  "d4");
    step(0, 1, 'h30, 0, 0, 1, 1, 0, 1, 'h20,  "d5");
    step(0, 0, 0,    0, 0, 1, 1, 0, 1, 'h30,  "d6");
    step(0, 0, 0,    0, 0, 1, 1, 0, 0, 0,     "d7");

    // Reset with both output and hold occupied: neither packet may ever appear.
    step(0, 1, 'h40, 0, 0,    1, 1, 0, 0, 0,     "e0");
    step(0, 1, 'h50, 0, 0,    0, 1, 0, 1, 'h40,  "e1");
    step(1, 1, 'h60, 1, 'h61, 0, 0, 0, 1, 'h40,  "e2");
    step(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     "e3");
    step(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     "e4");
    check("directed_pending", DW'(exp_q.size()), 0);

    // Random traffic: sources hold valid until accepted; ring/local tagged by MSB.
    rand_mode = 1'b1;
    rid = 1; lid = 1; wait_cnt = 0;
    ring_in_valid = 1'b0; local_req_valid = 1'b0;
    for (int c = 0; c < 10060; c++) begin
      gen = (c < 10000);
      @(negedge clk);
      acc_r = ring_in_valid && ring_in_ready;
      acc_l = local_req_valid && local_req_ready;
      if (acc_r) ring_q.push_back(ring_in_data);
      if (acc_l) loc_q.push_back(local_req_data);
      if (local_req_valid && !local_req_ready && (!ring_out_valid || ring_out_ready)) wait_cnt++;
      if (acc_l) begin
        check("local_wait_bound", DW'(wait_cnt <= SL + 1), 1);
        wait_cnt = 0;
      end
      @(posedge clk);
      #1;
      if (!ring_in_valid || acc_r) begin
        ring_in_valid = gen && ($urandom_range(0, 9) < 6);
        ring_in_data  = {1'b0, rid[DW-2:0]};
        if (ring_in_valid) rid++;
      end
      if (!local_req_valid || acc_l) begin
        local_req_valid = gen && ($urandom_range(0, 9) < 3);
        local_req_data  = {1'b1, lid[DW-2:0]};
        if (local_req_valid) lid++;
      end
      ring_out_ready = !gen || ($urandom_range(0, 9) < 7);
    end

    check("drain_ring_valid", DW'(ring_in_valid), 0);
    check("drain_local_valid", DW'(local_req_valid), 0);
    check("ring_q_empty", DW'(ring_q.size()), 0);
    check("loc_q_empty", DW'(loc_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
